// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX-flush bubbling,
// writeback-to-capture bypass and a saturating load-use bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int CTL_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [2:0]        id_read_reg1,
  input  logic [2:0]        id_read_reg2,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [DATA_W-1:0] id_rs,
  input  logic [DATA_W-1:0] id_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_w1_reg,
  input  logic              id_reg_en,
  input  logic              id_mem_read,
  input  logic [CTL_W-1:0]  id_ctl,
  input  logic              flush_ex,
  input  logic [2:0]        w1_reg_MEM_WB,
  input  logic              reg_en_MEM_WB,
  input  logic [DATA_W-1:0] writedata_MEM_WB,
  output logic              ex_valid,
  output logic [2:0]        ex_read_reg1,
  output logic [2:0]        ex_read_reg2,
  output logic [DATA_W-1:0] ex_rs,
  output logic [DATA_W-1:0] ex_rt,
  output logic [DATA_W-1:0] ex_imm,
  output logic [2:0]        ex_w1_reg,
  output logic              ex_reg_en,
  output logic              ex_mem_read,
  output logic [CTL_W-1:0]  ex_ctl,
  output logic              stall_id,
  output logic [15:0]       stall_cnt
);

  logic              valid_q,    valid_d;
  logic [2:0]        rreg1_q,    rreg1_d;
  logic [2:0]        rreg2_q,    rreg2_d;
  logic [DATA_W-1:0] rs_q,       rs_d;
  logic [DATA_W-1:0] rt_q,       rt_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [2:0]        w1_q,       w1_d;
  logic              reg_en_q,   reg_en_d;
  logic              mem_read_q, mem_read_d;
  logic [CTL_W-1:0]  ctl_q,      ctl_d;
  logic [15:0]       cnt_q,      cnt_d;

  logic hazard;
  logic bubble;

  // Load-use: the load in EX has not produced data yet, so a dependent decode must wait.
  assign hazard = id_valid & valid_q & mem_read_q & reg_en_q &
                  ((id_rs_used & (id_read_reg1 == w1_q)) |
                   (id_rt_used & (id_read_reg2 == w1_q)));
  assign stall_id = hazard & ~flush_ex;
  assign bubble   = stall_id | flush_ex;

  always_comb begin
    valid_d    = valid_q;
    rreg1_d    = rreg1_q;
    rreg2_d    = rreg2_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    imm_d      = imm_q;
    w1_d       = w1_q;
    reg_en_d   = reg_en_q;
    mem_read_d = mem_read_q;
    ctl_d      = ctl_q;
    cnt_d      = cnt_q;
    if (bubble) begin
      // Operand fields hold; only the side-effecting controls are killed.
      valid_d    = 1'b0;
      reg_en_d   = 1'b0;
      mem_read_d = 1'b0;
      ctl_d      = '0;
    end else begin
      valid_d    = id_valid;
      rreg1_d    = id_read_reg1;
      rreg2_d    = id_read_reg2;
      rs_d       = (reg_en_MEM_WB && (w1_reg_MEM_WB == id_read_reg1)) ? writedata_MEM_WB : id_rs;
      rt_d       = (reg_en_MEM_WB && (w1_reg_MEM_WB == id_read_reg2)) ? writedata_MEM_WB : id_rt;
      imm_d      = id_imm;
      w1_d       = id_w1_reg;
      reg_en_d   = id_valid & id_reg_en;
      mem_read_d = id_valid & id_mem_read;
      ctl_d      = id_ctl;
    end
    if (stall_id && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rreg1_q    <= '0;
      rreg2_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      w1_q       <= '0;
      reg_en_q   <= 1'b0;
      mem_read_q <= 1'b0;
      ctl_q      <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rreg1_q    <= rreg1_d;
      rreg2_q    <= rreg2_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      imm_q      <= imm_d;
      w1_q       <= w1_d;
      reg_en_q   <= reg_en_d;
      mem_read_q <= mem_read_d;
      ctl_q      <= ctl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_read_reg1 = rreg1_q;
  assign ex_read_reg2 = rreg2_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_imm       = imm_q;
  assign ex_w1_reg    = w1_q;
  assign ex_reg_en    = reg_en_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_ctl       = ctl_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/bypass/saturation/reset
// scenarios followed by randomized traffic, all checked against a rule-level model.
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs_used, id_rt_used, id_reg_en, id_mem_read, flush_ex;
  logic [2:0]    id_read_reg1, id_read_reg2, id_w1_reg, w1_reg_MEM_WB;
  logic [DW-1:0] id_rs, id_rt, id_imm, writedata_MEM_WB;
  logic [CW-1:0] id_ctl;
  logic          reg_en_MEM_WB;
  logic          ex_valid, ex_reg_en, ex_mem_read, stall_id;
  logic [2:0]    ex_read_reg1, ex_read_reg2, ex_w1_reg;
  logic [DW-1:0] ex_rs, ex_rt, ex_imm;
  logic [CW-1:0] ex_ctl;
  logic [15:0]   stall_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CTL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rs(id_rs), .id_rt(id_rt),
    .id_imm(id_imm), .id_w1_reg(id_w1_reg), .id_reg_en(id_reg_en),
    .id_mem_read(id_mem_read), .id_ctl(id_ctl), .flush_ex(flush_ex),
    .w1_reg_MEM_WB(w1_reg_MEM_WB), .reg_en_MEM_WB(reg_en_MEM_WB),
    .writedata_MEM_WB(writedata_MEM_WB),
    .ex_valid(ex_valid), .ex_read_reg1(ex_read_reg1), .ex_read_reg2(ex_read_reg2),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_w1_reg(ex_w1_reg),
    .ex_reg_en(ex_reg_en), .ex_mem_read(ex_mem_read), .ex_ctl(ex_ctl),
    .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  // Reference view of the EX slot.
  typedef struct {
    logic          valid;
    logic [2:0]    r1, r2, w1;
    logic [DW-1:0] rs, rt, imm;
    logic          reg_en, mem_read;
    logic [CW-1:0] ctl;
    int            cnt;
  } ex_t;
  ex_t m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m.valid = 0; m.r1 = 0; m.r2 = 0; m.w1 = 0; m.rs = 0; m.rt = 0; m.imm = 0;
    m.reg_en = 0; m.mem_read = 0; m.ctl = 0; m.cnt = 0;
  endfunction

  function automatic logic model_stall();
    logic dep;
    dep = (id_rs_used && id_read_reg1 == m.w1) || (id_rt_used && id_read_reg2 == m.w1);
    return id_valid && m.valid && m.mem_read && m.reg_en && dep && !flush_ex;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},    ex_valid,     m.valid);
    check({tag, ".r1"},       ex_read_reg1, m.r1);
    check({tag, ".r2"},       ex_read_reg2, m.r2);
    check({tag, ".rs"},       ex_rs,        m.rs);
    check({tag, ".rt"},       ex_rt,        m.rt);
    check({tag, ".imm"},      ex_imm,       m.imm);
    check({tag, ".w1"},       ex_w1_reg,    m.w1);
    check({tag, ".reg_en"},   ex_reg_en,    m.reg_en);
    check({tag, ".mem_read"}, ex_mem_read,  m.mem_read);
    check({tag, ".ctl"},      ex_ctl,       m.ctl);
    check({tag, ".cnt"},      stall_cnt,    m.cnt[15:0]);
  endtask

  // Inputs are already driven; check stall, take one edge, update model, check EX slot.
  task automatic cycle(input string tag);
    logic s;
    #1;
    s = model_stall();
    check({tag, ".stall"}, stall_id, s);
    @(posedge clk);
    if (s || flush_ex) begin
      m.valid = 0; m.reg_en = 0; m.mem_read = 0; m.ctl = 0;
      if (s && m.cnt < 65535) m.cnt = m.cnt + 1;
    end else begin
      m.valid    = id_valid;
      m.r1       = id_read_reg1;
      m.r2       = id_read_reg2;
      m.rs       = (reg_en_MEM_WB && w1_reg_MEM_WB == id_read_reg1) ? writedata_MEM_WB : id_rs;
      m.rt       = (reg_en_MEM_WB && w1_reg_MEM_WB == id_read_reg2) ? writedata_MEM_WB : id_rt;
      m.imm      = id_imm;
      m.w1       = id_w1_reg;
      m.reg_en   = id_valid && id_reg_en;
      m.mem_read = id_valid && id_mem_read;
      m.ctl      = id_ctl;
    end
    #1;
    check_outputs(tag);
    $display("cycle %-10s stall=%0b ex_valid=%0b ex_w1=%0d ex_rs=%h cnt=%0d",
             tag, stall_id, ex_valid, ex_w1_reg, ex_rs, stall_cnt);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_read_reg1 = 0; id_read_reg2 = 0; id_rs_used = 0; id_rt_used = 0;
    id_rs = 0; id_rt = 0; id_imm = 0; id_w1_reg = 0; id_reg_en = 0; id_mem_read = 0;
    id_ctl = 0; flush_ex = 0; w1_reg_MEM_WB = 0; reg_en_MEM_WB = 0; writedata_MEM_WB = 0;
  endtask

  task automatic load(input logic [2:0] dst);
    id_valid = 1; id_mem_read = 1; id_reg_en = 1; id_w1_reg = dst;
    id_rs_used = 0; id_rt_used = 0; id_read_reg1 = 3'd0; id_read_reg2 = 3'd0;
    id_ctl = 8'h5A; id_imm = 16'h0004; id_rs = 16'h1000; id_rt = 16'h2000;
  endtask

  task automatic alu_rs(input logic [2:0] src, input logic [2:0] dst);
    id_valid = 1; id_mem_read = 0; id_reg_en = 1; id_w1_reg = dst;
    id_rs_used = 1; id_rt_used = 0; id_read_reg1 = src; id_read_reg2 = 3'd6;
    id_ctl = 8'hA1; id_imm = 16'h0000; id_rs = 16'h3333; id_rt = 16'h4444;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #12;
    check_outputs("reset");
    check("reset.stall", stall_id, 1'b0);
    rst_n = 1;
    @(posedge clk); #1;

    // LD r3 then dependent ADD: one bubble, then ADD advances.
    load(3'd3);         cycle("ld_r3");
    alu_rs(3'd3, 3'd4);
    #1 check("ldu.stall_hi", stall_id, 1'b1);
    cycle("ldu_bub");
    check("ldu.bub_valid", ex_valid, 1'b0);
    check("ldu.cnt1", stall_cnt, 16'd1);
    cycle("ldu_adv");
    check("ldu.adv_valid", ex_valid, 1'b1);
    check("ldu.adv_w1", ex_w1_reg, 3'd4);

    // Same hazard under flush: no stall, bubble, counter untouched.
    load(3'd3);         cycle("ld_r3b");
    alu_rs(3'd3, 3'd4); flush_ex = 1;
    #1 check("flush.stall_lo", stall_id, 1'b0);
    cycle("flush");
    check("flush.valid", ex_valid, 1'b0);
    check("flush.cnt", stall_cnt, 16'd1);
    flush_ex = 0;

    // Writeback bypass on capture, including r0.
    alu_rs(3'd5, 3'd1); id_rs = 16'h0000;
    reg_en_MEM_WB = 1; w1_reg_MEM_WB = 3'd5; writedata_MEM_WB = 16'hBEEF;
    cycle("wb_byp");
    check("wb_byp.rs", ex_rs, 16'hBEEF);
    alu_rs(3'd0, 3'd1); w1_reg_MEM_WB = 3'd0; writedata_MEM_WB = 16'hCAFE;
    cycle("wb_r0");
    check("wb_r0.rs", ex_rs, 16'hCAFE);
    reg_en_MEM_WB = 0;

    // Matching register number but no operand use: no stall.
    load(3'd2);         cycle("ld_r2");
    alu_rs(3'd2, 3'd1); id_rs_used = 0; id_rt_used = 0; id_read_reg2 = 3'd2;
    #1 check("nouse.stall", stall_id, 1'b0);
    cycle("nouse");
    check("nouse.valid", ex_valid, 1'b1);

    // Invalid decode slot captured as a harmless bubble.
    load(3'd1); id_valid = 0;
    cycle("invalid");

    // Saturation: bring the counter near the top, then hazard twice.
    #2;
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m.cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      load(3'd7);         cycle("sat_ld");
      alu_rs(3'd7, 3'd1); cycle("sat_bub");
      cycle("sat_adv");
    end
    check("sat.cnt", stall_cnt, 16'hFFFF);

    // Asynchronous reset mid-stall, between edges.
    load(3'd4);         cycle("rst_ld");
    alu_rs(3'd4, 3'd1);
    #2 check("rst.pre_stall", stall_id, 1'b1);
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.stall", stall_id, 1'b0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    cycle("rst_rep");
    check("rst_rep.valid", ex_valid, 1'b1);

    // Randomized traffic over a small register space so hazards are frequent.
    for (int i = 0; i < 1500; i++) begin
      id_valid         = ($urandom_range(0, 9) != 0);
      id_read_reg1     = 3'($urandom_range(0, 3));
      id_read_reg2     = 3'($urandom_range(0, 3));
      id_rs_used       = 1'($urandom);
      id_rt_used       = 1'($urandom);
      id_rs            = 16'($urandom);
      id_rt            = 16'($urandom);
      id_imm           = 16'($urandom);
      id_w1_reg        = 3'($urandom_range(0, 3));
      id_reg_en        = ($urandom_range(0, 3) != 0);
      id_mem_read      = 1'($urandom);
      id_ctl           = 8'($urandom);
      flush_ex         = ($urandom_range(0, 9) == 0);
      w1_reg_MEM_WB    = 3'($urandom_range(0, 3));
      reg_en_MEM_WB    = 1'($urandom);
      writedata_MEM_WB = 16'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
